arb_rr_hold: RTL and testbench
==============================

ARB_RR_HOLD -- requirements
Module: arb_rr_hold

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting agents; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when others are waiting; legal range 1..255.
REQ-003 Port clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  NUM_REQ  active-high request, bit i from agent i.
REQ-006 Port gnt  output  NUM_REQ  active-high grant, one-hot or all-zero, registered.
REQ-007 Port gnt_valid  output  1  high when any gnt bit is high, registered.
REQ-008 Port gnt_id  output  clog2(NUM_REQ)  index of granted agent; 0 when gnt_valid low.
REQ-009 Port lock  input  1  present only when ARB_LOCK_EN is defined; holds the current grant beyond MAX_HOLD.

Function
REQ-010 Two states: IDLE (no owner) and GRANT (one owner).
REQ-011 Priority pointer ptr, clog2(NUM_REQ) bits; the search starts at ptr and wraps modulo NUM_REQ, so the first asserted req bit at or after ptr wins.
REQ-012 IDLE, req all zero: stay in IDLE with gnt zero.
REQ-013 IDLE, any req high: at the next edge enter GRANT with the winner's gnt bit set; latency from req sampled to gnt high is 1 cycle.
REQ-014 GRANT, owner's req still high, hold count below MAX_HOLD-1 or no other req high: keep the grant; the hold count increments and saturates at MAX_HOLD-1.
REQ-015 GRANT, owner's req still high, hold count equal to MAX_HOLD-1, and another req high: preempt; at the next edge grant the next winner searched from owner+1, with no dead cycle.
REQ-016 GRANT, owner's req low, another req high: re-arbitrate from owner+1; the new gnt appears at the next edge with no dead cycle.
REQ-017 GRANT, owner's req low, no req high: return to IDLE with gnt zero at the next edge.
REQ-018 On every new grant or return to IDLE, set ptr to (previous owner+1) mod NUM_REQ.
REQ-019 On every new grant, reset the hold count to 0.
REQ-020 The owner is never re-granted through preemption while another requester is pending.
REQ-021 No agent waits more than (NUM_REQ-1)*MAX_HOLD+1 cycles from req high to gnt high while its req stays high (lock inactive).

Reset
REQ-022 Reset asserted, at any time including mid-grant, immediately forces: state IDLE, gnt zero, gnt_valid 0, gnt_id 0, ptr 0, hold count 0.
REQ-023 The first edge after reset deasserts performs a normal IDLE arbitration from ptr 0.

Configuration
REQ-024 Macro ARB_LOCK_EN defined: the lock port exists; while lock is high in GRANT and the owner's req is high, preemption per REQ-015 is suppressed and the hold count does not increment.
REQ-025 Macro ARB_LOCK_EN defined: an owner whose req drops releases the grant per REQ-016/017 regardless of lock.
REQ-026 Macro ARB_LOCK_EN undefined: no lock port exists and behaviour is exactly REQ-010..REQ-021.

Verification (NUM_REQ=4, MAX_HOLD=4)
REQ-027 Reset pulse mid-grant of agent 2 -> gnt=0000, gnt_valid=0 and gnt_id=0 asynchronously, before the next edge.
REQ-028 req=0001 for 10 cycles, no other req -> gnt=0001 from cycle 1 for all remaining cycles, no preemption.
REQ-029 req=1111 held -> grants 0001,0010,0100,1000,0001, each held exactly 4 cycles, transitions with no zero cycle.
REQ-030 After agent 1 releases, req=0101 -> gnt=0100 (ptr=2), then 0001 after 4 cycles.
REQ-031 Agent 3 granted, req drops to 0000 -> next edge gnt=0000 and IDLE; then req=0011 -> gnt=0001 (wrap from ptr 0).
REQ-032 ARB_LOCK_EN defined, lock=1, req=0011 with agent 0 owner -> gnt=0001 held 10 cycles; lock=0 -> gnt=0010 at the next edge.

Source files
------------

// File: rtl/arb_rr_hold.sv
// Round-robin arbiter with per-owner hold limit; registered grant, 1-cycle req-to-gnt latency.
// Optional ARB_LOCK_EN macro adds a lock input that lets the owner keep its grant past MAX_HOLD.
module arb_rr_hold #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic                       lock,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               gnt_valid_d;
  logic [IDW-1:0]     gnt_id_d;

  logic               lock_act;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] others;
  logic               others_pend;
  logic               owner_req;
  logic [IDW-1:0]     owner_inc;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // First asserted bit at or after start, wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     start);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign owner_mask  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
  assign others      = req & ~owner_mask;
  assign others_pend = |others;
  assign owner_req   = |(req & owner_mask);
  assign owner_inc   = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
    end
  end

  // The owner sits last in a search from owner+1, so preemption never re-picks it.
  always_comb begin
    state_d = state_q;
    id_d    = gnt_id;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          id_d    = rr_pick(req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (owner_req) begin
          if (others_pend && (hold_q == HOLD_LAST) && !lock_act) begin
            id_d   = rr_pick(others, owner_inc);
            ptr_d  = owner_inc;
            hold_d = '0;
          end else if (!lock_act && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + 8'd1;
          end
        end else if (others_pend) begin
          id_d   = rr_pick(others, owner_inc);
          ptr_d  = owner_inc;
          hold_d = '0;
        end else begin
          state_d = IDLE;
          ptr_d   = owner_inc;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_id_d    = '0;
    if (state_d == GRANT) begin
      gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_d;
      gnt_valid_d = 1'b1;
      gnt_id_d    = id_d;
    end
  end

endmodule

// File: tb/tb_arb_rr_hold.sv
// Bench for arb_rr_hold (NUM_REQ=4, MAX_HOLD=4): directed scenarios plus randomized traffic
// compared against a tenure-counting reference model.
module tb_arb_rr_hold;
  localparam int N     = 4;
  localparam int MH    = 4;
  localparam int BOUND = (N - 1) * MH + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         lock;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = none), search pointer, cycles owned (frozen while locked).
  int m_owner, m_ptr, m_ten;

  always #5 clk = ~clk;

  arb_rr_hold #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clock     (clk),
    .reset     (rst),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    if (m_owner < 0) return '0;
    return N'(1) << m_owner;
  endfunction

  function automatic int m_id();
    return (m_owner < 0) ? 0 : m_owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_ten   = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic lk);
    logic [N-1:0] others;
    int nxt;
    if (m_owner < 0) begin
      if (search(r, m_ptr) >= 0) begin
        m_owner = search(r, m_ptr);
        m_ten   = 1;
      end
    end else begin
      nxt    = (m_owner + 1) % N;
      others = r & ~(N'(1) << m_owner);
      if (r[m_owner]) begin
        if (others != 0 && m_ten >= MH && !lk) begin
          m_owner = search(others, nxt);
          m_ptr   = nxt;
          m_ten   = 1;
        end else if (!lk) begin
          m_ten++;
        end
      end else if (others != 0) begin
        m_owner = search(others, nxt);
        m_ptr   = nxt;
        m_ten   = 1;
      end else begin
        m_owner = -1;
        m_ptr   = nxt;
        m_ten   = 0;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic lk);
    req  = r;
    lock = lk;
    @(posedge clk);
    model_edge(r, lk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    lock = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; lock = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", gnt_id); end
    rst = 1'b0;
    step(4'b0010, 1'b0);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL first_arb got %b want 0010", gnt); end
    step(4'b0100, 1'b0);
    checks++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin errors++; $display("FAIL agent2_grant got %b/%0d want 0100/2", gnt, gnt_id); end
    #2 rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL async_rst_gnt got %b want 0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", gnt_valid); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL async_rst_id got %0d want 0", gnt_id); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1'b0);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ptr_after_reset got %b want 0001", gnt); end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(4'b0001, 1'b0);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_hold cyc %0d got %b want 0001", k, gnt); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(4'b1111, 1'b0);
      e = N'(1) << (((k - 1) / MH) % N);
      checks++; if (gnt !== e || gnt_valid !== 1'b1) begin errors++; $display("FAIL rr_rotate cyc %0d got %b/%b want %b/1", k, gnt, gnt_valid, e); end
    end
  endtask

  task automatic test_release();
    logic [N-1:0] e;
    do_reset();
    step(4'b0010, 1'b0);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL release_setup got %b want 0010", gnt); end
    for (int k = 1; k <= 5; k++) begin
      step(4'b0101, 1'b0);
      e = (k <= MH) ? 4'b0100 : 4'b0001;
      checks++; if (gnt !== e) begin errors++; $display("FAIL release_rearb cyc %0d got %b want %b", k, gnt, e); end
    end
  endtask

  task automatic test_idle_wrap();
    do_reset();
    step(4'b1000, 1'b0);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_setup got %b want 1000", gnt); end
    step(4'b0000, 1'b0);
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin errors++; $display("FAIL to_idle got %b/%b/%0d want 0000/0/0", gnt, gnt_valid, gnt_id); end
    step(4'b0011, 1'b0);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0 got %b want 0001", gnt); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b0001, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(4'b0011, 1'b1);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_hold cyc %0d got %b want 0001", k, gnt); end
    end
    step(4'b0011, 1'b0);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_release got %b want 0010", gnt); end
    step(4'b0001, 1'b1);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_drop got %b want 0001", gnt); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    logic lk;
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) r = N'($urandom_range(0, 15));
`ifdef ARB_LOCK_EN
      lk = ($urandom_range(0, 7) == 0);
`else
      lk = 1'b0;
`endif
      step(r, lk);
      checks++;
      if (gnt !== m_gnt() || gnt_id !== 2'(m_id()) || gnt_valid !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL random cyc %0d req %b got %b/%0d/%b want %b/%0d/%b", c, r, gnt, gnt_id, gnt_valid, m_gnt(), m_id(), m_owner >= 0);
      end
    end
  endtask

  // Requesters keep req high until served for a random tenure; latency must stay bounded.
  task automatic test_starvation();
    logic [N-1:0] r, prev_g;
    int wait_c[N], held[N], want[N];
    do_reset();
    r = '0;
    prev_g = '0;
    for (int i = 0; i < N; i++) begin wait_c[i] = 0; held[i] = 0; want[i] = 1; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (gnt[i]) begin
            held[i]++;
            if (held[i] >= want[i]) r[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          r[i] = 1'b1; want[i] = $urandom_range(1, 6); held[i] = 0; wait_c[i] = 0;
        end
      end
      step(r, 1'b0);
      checks++;
      if (gnt !== m_gnt()) begin errors++; $display("FAIL sticky cyc %0d req %b got %b want %b", c, r, gnt, m_gnt()); end
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (gnt[i] && !prev_g[i]) begin
            checks++;
            if (wait_c[i] + 1 > BOUND) begin errors++; $display("FAIL wait_bound agent %0d got %0d want <= %0d", i, wait_c[i] + 1, BOUND); end
            wait_c[i] = 0;
          end else if (!gnt[i]) begin
            wait_c[i]++;
          end
        end
      end
      prev_g = gnt;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_release();
    test_idle_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    test_starvation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
